// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register sequencing (inc/branch/jump/vector); PC_SEQ_DEC_EN enables DEC.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] VEC_NMI  = 16'hFFFA,
  parameter logic [15:0] VEC_RST  = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ  = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_offset,
  input  logic [7:0]  cmd_low,
  input  logic [7:0]  cmd_high,
  input  logic [1:0]  cmd_vec_sel,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pc_low,
  output logic [7:0]  pc_high,
  output logic        page_cross
);
  typedef enum logic [2:0] {RV_LO, RV_HI, IDLE, BR_FIX, VEC_LO, VEC_HI} state_t;
  state_t state, state_nxt;
  logic [15:0] pc, pc_nxt, base, base_nxt, vec_base, rd_addr;
  logic [7:0] tmp, tmp_nxt;
  logic [8:0] br_sum;
  logic fix_dn, fix_dn_nxt, br_fix, fetch, hi_phase, accept;
  always_comb begin
    br_sum = {1'b0, pc[7:0]} + {1'b0, cmd_offset};
    // fix needed when carry disagrees with offset sign
    br_fix = cmd_offset[7] ^ br_sum[8];
    vec_base = cmd_vec_sel == 2'b00 ? VEC_NMI : cmd_vec_sel == 2'b01 ? VEC_RST : VEC_IRQ;
    fetch = state inside {RV_LO, RV_HI, VEC_LO, VEC_HI};
    hi_phase = state inside {RV_HI, VEC_HI};
    rd_addr = ((state inside {RV_LO, RV_HI}) ? VEC_RST : base) + {15'd0, hi_phase};
    cmd_ready = state == IDLE;
    mem_rd = fetch & ~rst;
    mem_addr = mem_rd ? rd_addr : 16'h0000;
    page_cross = state == BR_FIX;
    accept = cmd_valid & cmd_ready;
    state_nxt = state;
    pc_nxt = pc;
    tmp_nxt = tmp;
    base_nxt = base;
    fix_dn_nxt = fix_dn;
    case (state)
      RV_LO, VEC_LO: begin
        tmp_nxt = mem_rdata;
        state_nxt = state == RV_LO ? RV_HI : VEC_HI;
      end
      RV_HI, VEC_HI: begin
        pc_nxt = {mem_rdata, tmp};
        state_nxt = IDLE;
      end
      BR_FIX: begin
        pc_nxt[15:8] = pc[15:8] + (fix_dn ? 8'hFF : 8'h01);
        state_nxt = IDLE;
      end
      default: if (accept) begin
        case (cmd_op)
          3'b001: pc_nxt = pc + 16'd1;
          3'b010: begin
            pc_nxt = {pc[15:8], br_sum[7:0]};
            fix_dn_nxt = cmd_offset[7];
            state_nxt = br_fix ? BR_FIX : IDLE;
          end
          3'b011: pc_nxt = {cmd_high, cmd_low};
          3'b100: begin
            base_nxt = vec_base;
            state_nxt = VEC_LO;
          end
`ifdef PC_SEQ_DEC_EN
          3'b101: pc_nxt = pc - 16'd1;
`else
          3'b101: pc_nxt = pc;
`endif
          default: pc_nxt = pc;
        endcase
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RV_LO;
      pc <= RESET_PC;
      tmp <= 8'h00;
      base <= 16'h0000;
      fix_dn <= 1'b0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      tmp <= tmp_nxt;
      base <= base_nxt;
      fix_dn <= fix_dn_nxt;
    end
  end
  assign pc_low = pc[7:0];
  assign pc_high = pc[15:8];
endmodule
